// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial sequence detector with KMP fallback and run-time overlap select.
// Optional saturating match counter is built when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detector_param #(
  parameter int unsigned            PAT_WIDTH = 3,
  parameter logic [PAT_WIDTH-1:0]   PATTERN   = 3'b101,
  parameter int unsigned            CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 R,
  input  logic                 in,
  input  logic                 en,
  input  logic                 overlap,
  output logic                 out,
  output logic                 partial,
  output logic [CNT_WIDTH-1:0] match_cnt
);

  localparam int unsigned SW = (PAT_WIDTH > 2) ? $clog2(PAT_WIDTH) : 1;
  localparam int unsigned NT = 2 ** SW;

  // Pattern bit k in arrival order (k=0 is the first bit received).
  function automatic logic pat_bit(int unsigned k);
    logic [PAT_WIDTH-1:0] t;
    t = PATTERN >> (PAT_WIDTH - 1 - k);
    return t[0];
  endfunction

  // Longest pattern prefix that is a suffix of (prefix of length s) followed by b.
  function automatic int unsigned kmp_next(int unsigned s, logic b);
    int unsigned res;
    int unsigned p;
    logic        ok;
    logic        c;
    res = 0;
    for (int unsigned j = 1; j <= s + 1; j++) begin
      ok = 1'b1;
      for (int unsigned k = 0; k < j; k++) begin
        p = s + 1 - j + k;
        c = (p < s) ? pat_bit(p) : b;
        if (c != pat_bit(k)) ok = 1'b0;
      end
      if (ok) res = j;
    end
    return res;
  endfunction

  function automatic int unsigned fallback();
    int unsigned res;
    logic        ok;
    res = 0;
    for (int unsigned j = 1; j < PAT_WIDTH; j++) begin
      ok = 1'b1;
      for (int unsigned k = 0; k < j; k++)
        if (pat_bit(k) != pat_bit(PAT_WIDTH - j + k)) ok = 1'b0;
      if (ok) res = j;
    end
    return res;
  endfunction

  localparam logic [SW-1:0] LAST = SW'(PAT_WIDTH - 1);
  localparam logic [SW-1:0] FB   = SW'(fallback());

  logic [SW-1:0] st;
  logic [SW-1:0] st_next;
  logic [SW-1:0] nxt0 [NT];
  logic [SW-1:0] nxt1 [NT];

  // Non-match transitions only; the match edge is resolved by overlap below.
  for (genvar g = 0; g < NT; g++) begin : g_tab
    if (g < PAT_WIDTH) begin : g_live
      localparam int unsigned   N0 = kmp_next(g, 1'b0);
      localparam int unsigned   N1 = kmp_next(g, 1'b1);
      localparam logic [SW-1:0] V0 = (N0 >= PAT_WIDTH) ? '0 : SW'(N0);
      localparam logic [SW-1:0] V1 = (N1 >= PAT_WIDTH) ? '0 : SW'(N1);
      assign nxt0[g] = V0;
      assign nxt1[g] = V1;
    end else begin : g_pad
      assign nxt0[g] = '0;
      assign nxt1[g] = '0;
    end
  end

  assign out     = en & ~R & (st == LAST) & (in == PATTERN[0]);
  assign partial = (st != '0);

  always_comb begin
    st_next = st;
    if (R)
      st_next = '0;
    else if (en) begin
      if (out)
        st_next = overlap ? FB : '0;
      else
        st_next = in ? nxt1[st] : nxt0[st];
    end
  end

  always_ff @(posedge clk) begin
    st <= st_next;
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  always_ff @(posedge clk) begin
    if (R)
      match_cnt <= '0;
    else if (out && (match_cnt != '1))
      match_cnt <= match_cnt + 1'b1;
  end
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Table-driven bench for seq_detector_param: three instances (101, 1101, 101 with 2-bit counter)
// share the input stimulus; each vector names which instance it checks.
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r, en, din, ov;
  logic out_a, part_a, out_b, part_b, out_c, part_c;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic [1:0] cnt_c;

  seq_detector_param #(.PAT_WIDTH(3), .PATTERN(3'b101), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .R(r), .in(din), .en(en), .overlap(ov),
    .out(out_a), .partial(part_a), .match_cnt(cnt_a));

  seq_detector_param #(.PAT_WIDTH(4), .PATTERN(4'b1101), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .R(r), .in(din), .en(en), .overlap(ov),
    .out(out_b), .partial(part_b), .match_cnt(cnt_b));

  seq_detector_param #(.PAT_WIDTH(3), .PATTERN(3'b101), .CNT_WIDTH(2)) dut_c (
    .clk(clk), .R(r), .in(din), .en(en), .overlap(ov),
    .out(out_c), .partial(part_c), .match_cnt(cnt_c));

  typedef struct {
    int unsigned sel;
    logic r, en, i, ov;
    logic eout, epart;
    int unsigned ecnt;   // counter value with the counter built
  } vec_t;

  vec_t vq[$];
  int checks   = 0;
  int failures = 0;

  function automatic void add(int unsigned sel, logic vr, logic ven, logic vi, logic vov,
                              logic eo, logic ep, int unsigned ec);
    vec_t v;
    v.sel = sel; v.r = vr; v.en = ven; v.i = vi; v.ov = vov;
    v.eout = eo; v.epart = ep; v.ecnt = ec;
    vq.push_back(v);
  endfunction

  task automatic check(string name, int idx, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h exp=%0h", name, idx, got, exp);
    end
  endtask

  function automatic logic get_out(int unsigned sel);
    return (sel == 0) ? out_a : (sel == 1) ? out_b : out_c;
  endfunction
  function automatic logic get_part(int unsigned sel);
    return (sel == 0) ? part_a : (sel == 1) ? part_b : part_c;
  endfunction
  function automatic logic [31:0] get_cnt(int unsigned sel);
    return (sel == 0) ? {24'd0, cnt_a} : (sel == 1) ? {24'd0, cnt_b} : {30'd0, cnt_c};
  endfunction

  task automatic apply(vec_t v, int idx);
    logic [31:0] ec;
`ifdef SEQ_DET_MATCH_CNT_EN
    ec = v.ecnt;
`else
    ec = 0;
`endif
    @(negedge clk);
    r = v.r; en = v.en; din = v.i; ov = v.ov;
    #1;
    check("out", idx, {31'd0, get_out(v.sel)}, {31'd0, v.eout});
    @(posedge clk);
    #1;
    check("partial", idx, {31'd0, get_part(v.sel)}, {31'd0, v.epart});
    check("match_cnt", idx, get_cnt(v.sel), ec);
  endtask

  initial begin
    r = 1'b1; en = 1'b0; din = 1'b0; ov = 1'b0;

    // A1: 101 non-overlapping
    add(0,1,0,0,0, 0,0,0);
    add(0,0,1,1,0, 0,1,0); add(0,0,1,0,0, 0,1,0); add(0,0,1,1,0, 1,0,1);
    add(0,0,1,0,0, 0,0,1); add(0,0,1,1,0, 0,1,1);
    // A2: 101 overlapping
    add(0,1,1,0,1, 0,0,0);
    add(0,0,1,1,1, 0,1,0); add(0,0,1,0,1, 0,1,0); add(0,0,1,1,1, 1,1,1);
    add(0,0,1,0,1, 0,1,1); add(0,0,1,1,1, 1,1,2);
    // A3: enable gap holds the prefix
    add(0,1,0,0,0, 0,0,0);
    add(0,0,1,1,0, 0,1,0); add(0,0,1,0,0, 0,1,0);
    add(0,0,0,1,0, 0,1,0); add(0,0,0,1,0, 0,1,0); add(0,0,0,1,0, 0,1,0);
    add(0,0,1,1,0, 1,0,1);
    // A4: reset on what would be the match edge
    add(0,1,0,0,1, 0,0,0);
    add(0,0,1,1,1, 0,1,0); add(0,0,1,0,1, 0,1,0);
    add(0,1,1,1,1, 0,0,0);
    add(0,0,1,1,1, 0,1,0); add(0,0,1,0,1, 0,1,0); add(0,0,1,1,1, 1,1,1);
    // B1: 1101 overlapping
    add(1,1,0,0,1, 0,0,0);
    add(1,0,1,1,1, 0,1,0); add(1,0,1,1,1, 0,1,0); add(1,0,1,0,1, 0,1,0);
    add(1,0,1,1,1, 1,1,1); add(1,0,1,1,1, 0,1,1); add(1,0,1,0,1, 0,1,1);
    add(1,0,1,1,1, 1,1,2);
    // B2: 1101 non-overlapping
    add(1,1,0,0,0, 0,0,0);
    add(1,0,1,1,0, 0,1,0); add(1,0,1,1,0, 0,1,0); add(1,0,1,0,0, 0,1,0);
    add(1,0,1,1,0, 1,0,1); add(1,0,1,1,0, 0,1,1); add(1,0,1,0,0, 0,0,1);
    add(1,0,1,1,0, 0,1,1);
    // B3: "111" keeps the "11" prefix
    add(1,1,0,0,0, 0,0,0);
    add(1,0,1,1,0, 0,1,0); add(1,0,1,1,0, 0,1,0); add(1,0,1,1,0, 0,1,0);
    add(1,0,1,0,0, 0,1,0); add(1,0,1,1,0, 1,0,1);
    // C1: 2-bit counter saturates on the fourth match
    add(2,1,0,0,1, 0,0,0);
    add(2,0,1,1,1, 0,1,0); add(2,0,1,0,1, 0,1,0); add(2,0,1,1,1, 1,1,1);
    add(2,0,1,0,1, 0,1,1); add(2,0,1,1,1, 1,1,2); add(2,0,1,0,1, 0,1,2);
    add(2,0,1,1,1, 1,1,3); add(2,0,1,0,1, 0,1,3); add(2,0,1,1,1, 1,1,3);

    foreach (vq[k]) apply(vq[k], k);

    // Held reset with pattern-completing input: strobe stays low, no prefix survives.
    @(negedge clk); r = 1'b1; en = 1'b0; ov = 1'b1;
    @(negedge clk); r = 1'b0; en = 1'b1; din = 1'b1;
    @(negedge clk); din = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); r = 1'b1; din = 1'b1;
      #1; check("hold_r_out", n, {31'd0, out_a}, 32'd0);
      @(posedge clk); #1;
      check("hold_r_partial", n, {31'd0, part_a}, 32'd0);
      check("hold_r_cnt", n, {24'd0, cnt_a}, 32'd0);
    end

    // Overlap toggling while a prefix is held does not discard it.
    @(negedge clk); r = 1'b0; din = 1'b1; ov = 1'b0;
    @(negedge clk); din = 1'b0; ov = 1'b1;
    @(posedge clk); #1;
    check("ov_toggle_partial", 0, {31'd0, part_a}, 32'd1);
    @(negedge clk); din = 1'b1; ov = 1'b0;
    #1; check("ov_toggle_out", 0, {31'd0, out_a}, 32'd1);
    @(posedge clk); #1;
    check("ov_toggle_after", 0, {31'd0, part_a}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
